// File: rtl/riscv_defs.sv
// Shared definitions for the branch redirect front-end control: FSM state
// encoding and default datapath width.
package riscv_defs;

    localparam int DEFAULT_XLEN = 32;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } redirect_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns the EX-stage redirect decision into PC select/enable and IF/ID, ID/EX
// flush control, holding the redirect while instruction memory is busy.
module branch_redirect_ctrl
    import riscv_defs::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             Branch,
    input  logic             ForceJump,
    input  logic             BranchMux,
    input  logic [XLEN-1:0]  target_pc,
    input  logic             imem_ready,
    input  logic             cnt_clr,
    output logic             pc_sel,
    output logic             pc_en,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    redirect_state_t state, state_nxt;
    logic            take;
    logic            take_idle;
    logic            count_branch;

    assign take = ex_valid & BranchMux;
    assign busy = (state == REDIRECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            redirect_pc <= '0;
        end else begin
            state <= state_nxt;
            if (take_idle) begin
                redirect_pc <= target_pc;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        pc_sel       = 1'b0;
        pc_en        = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        take_idle    = 1'b0;
        count_branch = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    take_idle    = take;
                    count_branch = ex_valid & (Branch | ForceJump);
                    if (take) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        state_nxt  = REDIRECT;
                    end else begin
                        pc_en = imem_ready;
                    end
                end
                REDIRECT: begin
                    // EX holds a bubble here, so any take is ignored.
                    pc_sel     = 1'b1;
                    pc_en      = imem_ready;
                    flush_ifid = 1'b1;
                    if (imem_ready) begin
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (count_branch),
        .q   (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (take_idle),
        .q   (taken_cnt)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs for
// every driven cycle; a monitor pops and compares them mid-cycle.
module tb_branch_redirect_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        bit        rst, ev, br, fj, bm, rdy, clr;
        bit [31:0] tgt;
    } stim_t;

    typedef struct {
        bit        pc_sel, pc_en, fi, fx, busy;
        bit [31:0] rpc;
        int        bc, tc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, ex_valid, Branch, ForceJump, BranchMux, imem_ready, cnt_clr;
    logic [XLEN-1:0]  target_pc;
    logic             pc_sel, pc_en, flush_ifid, flush_idex, busy;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_cnt, taken_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Reference model state: is a redirect pending, its target, and the two counts.
    bit        m_pending = 0;
    bit [31:0] m_rpc = 0;
    int        m_bc = 0, m_tc = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .Branch      (Branch),
        .ForceJump   (ForceJump),
        .BranchMux   (BranchMux),
        .target_pc   (target_pc),
        .imem_ready  (imem_ready),
        .cnt_clr     (cnt_clr),
        .pc_sel      (pc_sel),
        .pc_en       (pc_en),
        .redirect_pc (redirect_pc),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .busy        (busy),
        .branch_cnt  (branch_cnt),
        .taken_cnt   (taken_cnt)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    function automatic stim_t idle(input bit rdy);
        stim_t s;
        s = '{rst: 0, ev: 0, br: 0, fj: 0, bm: 0, rdy: rdy, clr: 0, tgt: 32'h0};
        return s;
    endfunction

    function automatic stim_t take_s(input bit [31:0] tgt, input bit rdy);
        stim_t s;
        s = '{rst: 0, ev: 1, br: 1, fj: 0, bm: 1, rdy: rdy, clr: 0, tgt: tgt};
        return s;
    endfunction

    // Apply one cycle of stimulus, record what the outputs must be this cycle,
    // then advance the model to the next cycle.
    task automatic drive(input stim_t s);
        exp_t e;
        bit   take;
        @(posedge clk);
        #1;
        rst        = s.rst;
        ex_valid   = s.ev;
        Branch     = s.br;
        ForceJump  = s.fj;
        BranchMux  = s.bm;
        imem_ready = s.rdy;
        cnt_clr    = s.clr;
        target_pc  = s.tgt;

        take = s.ev && s.bm;
        e.busy = m_pending;
        e.rpc  = m_rpc;
        e.bc   = m_bc;
        e.tc   = m_tc;
        if (s.rst) begin
            e.pc_sel = 0; e.pc_en = 0; e.fi = 0; e.fx = 0;
        end else if (m_pending) begin
            e.pc_sel = 1; e.pc_en = s.rdy; e.fi = 1; e.fx = 0;
        end else begin
            e.pc_sel = 0; e.pc_en = take ? 1'b0 : s.rdy; e.fi = take; e.fx = take;
        end
        sb_q.push_back(e);

        if (s.rst) begin
            m_pending = 0; m_rpc = 0; m_bc = 0; m_tc = 0;
        end else begin
            if (s.clr) begin
                m_bc = 0; m_tc = 0;
            end else if (!m_pending) begin
                if (s.ev && (s.br || s.fj) && m_bc < CMAX) m_bc++;
                if (take && m_tc < CMAX) m_tc++;
            end
            if (m_pending) begin
                m_pending = !s.rdy;
            end else if (take) begin
                m_pending = 1;
                m_rpc     = s.tgt;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc_sel",      {31'b0, pc_sel},     {31'b0, e.pc_sel});
                check("pc_en",       {31'b0, pc_en},      {31'b0, e.pc_en});
                check("flush_ifid",  {31'b0, flush_ifid}, {31'b0, e.fi});
                check("flush_idex",  {31'b0, flush_idex}, {31'b0, e.fx});
                check("busy",        {31'b0, busy},       {31'b0, e.busy});
                check("redirect_pc", redirect_pc,         e.rpc);
                check("branch_cnt",  {24'b0, branch_cnt}, e.bc);
                check("taken_cnt",   {24'b0, taken_cnt},  e.tc);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        rst = 1; ex_valid = 0; Branch = 0; ForceJump = 0; BranchMux = 0;
        imem_ready = 1; cnt_clr = 0; target_pc = '0;
        repeat (2) @(posedge clk);

        s = idle(1); s.rst = 1;
        drive(s);

        // Not-taken branches only count.
        s = idle(1); s.ev = 1; s.br = 1;
        repeat (3) drive(s);
        drive(idle(1));

        // Taken redirect with memory always ready.
        drive(take_s(32'h40, 1));
        drive(idle(1));
        drive(idle(1));

        // Redirect stalled by three not-ready cycles.
        drive(take_s(32'h40, 1));
        repeat (3) drive(idle(0));
        drive(idle(1));
        drive(idle(1));

        // Back-to-back take: the second (0x80) lands in REDIRECT and is ignored.
        s = idle(1); s.clr = 1;
        drive(s);
        drive(take_s(32'h40, 1));
        drive(take_s(32'h80, 1));
        drive(idle(1));

        // Bring both counters one below all-ones, then saturate.
        s = idle(1); s.clr = 1;
        drive(s);
        for (int i = 0; i < CMAX - 1 + 3; i++) begin
            drive(take_s(32'h100 + 32'(i * 4), 1));
            drive(idle(1));
        end
        s = take_s(32'h200, 1); s.clr = 1;
        drive(s);
        drive(idle(1));
        drive(idle(1));

        // Ignored controls without ex_valid.
        s = idle(1); s.br = 1; s.fj = 1; s.bm = 1; s.tgt = 32'hdead_beec;
        drive(s);

        // Reset while in REDIRECT drops the redirect.
        drive(take_s(32'h44, 1));
        s = idle(0); s.rst = 1;
        drive(s);
        drive(idle(0));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rst = ($urandom_range(0, 63) == 0);
            s.ev  = $urandom_range(0, 3) != 0;
            s.br  = $urandom_range(0, 1) == 1;
            s.fj  = $urandom_range(0, 3) == 0;
            s.bm  = $urandom_range(0, 2) == 0;
            s.rdy = $urandom_range(0, 3) != 0;
            s.clr = ($urandom_range(0, 31) == 0);
            s.tgt = $urandom() & 32'hffff_fffc;
            drive(s);
        end

        drive(idle(1));
        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
